// File: rtl/count4_enable_pkg.sv
// rtl/count4_enable_pkg.sv - shared counter width and default terminal value for count4_enable
package count4_enable_pkg;

    localparam int CNT_W           = 4;
    localparam int CNT_MAX_DEFAULT = 15;

endpackage

// File: rtl/count4_enable.sv
// rtl/count4_enable.sv - 4-bit enabled wrap-around counter with terminal-count flag
// Build macro COUNT4_ENABLE_TC_GATED_EN qualifies tc with enable (flags a wrap on the next edge).
module count4_enable
    import count4_enable_pkg::*;
#(
    parameter int MAX_COUNT = CNT_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_COUNT);

    if (MAX_COUNT < 1 || MAX_COUNT > ((1 << CNT_W) - 1)) begin : g_bad_max_count
        $error("count4_enable: MAX_COUNT=%0d outside legal range 1..15", MAX_COUNT);
    end

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    assign at_max  = (count_q == MAX_V);
    assign count_d = enable ? (at_max ? '0 : count_q + CNT_W'(1)) : count_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef COUNT4_ENABLE_TC_GATED_EN
    assign tc = at_max & enable;
`else
    assign tc = at_max;
`endif

endmodule

// File: tb/tb_count4_enable.sv
// tb/tb_count4_enable.sv - self-checking bench for count4_enable (default and MAX_COUNT=9 instances)
module tb_count4_enable;

    logic       clk;
    logic       clr;
    logic       enable;
    logic [3:0] count_a;
    logic       tc_a;
    logic [3:0] count_b;
    logic       tc_b;

    int vectors;
    int miscompares;
    int m_a;
    int m_b;

`ifdef COUNT4_ENABLE_TC_GATED_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    count4_enable u_dut_a (
        .clk    (clk),
        .clr    (clr),
        .enable (enable),
        .count  (count_a),
        .tc     (tc_a)
    );

    count4_enable #(.MAX_COUNT(9)) u_dut_b (
        .clk    (clk),
        .clr    (clr),
        .enable (enable),
        .count  (count_b),
        .tc     (tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_tc(input int m, input int max, input logic en, input logic c);
        if (!c) return 1'b0;
        if (GATED) return (m == max) && en;
        return (m == max);
    endfunction

    task automatic cmp4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic cmp1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all(input string tag);
        cmp4({tag, "/count15"}, count_a, 4'(m_a));
        cmp1({tag, "/tc15"}, tc_a, exp_tc(m_a, 15, enable, clr));
        cmp4({tag, "/count9"}, count_b, 4'(m_b));
        cmp1({tag, "/tc9"}, tc_b, exp_tc(m_b, 9, enable, clr));
    endtask

    // One clock: model follows the counting rule at the rising edge, checks sit on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (clr && enable) begin
            m_a = (m_a + 1) % 16;
            m_b = (m_b + 1) % 10;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic pulse_clr_mid(input string tag);
        #2;
        clr = 1'b0;
        m_a = 0;
        m_b = 0;
        #1;
        check_all({tag, "/async"});
        #1;
        clr = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_a         = 0;
        m_b         = 0;
        clr         = 1'b0;
        enable      = 1'b1;

        // Scenario 1: reset held 20 ns with clock running and enable high
        #1;
        check_all("rst_start");
        #6;
        check_all("rst_mid");
        @(negedge clk);
        check_all("rst_neg1");
        @(posedge clk);
        #1;
        check_all("rst_post_edge");
        @(negedge clk);
        enable = 1'b0;
        clr    = 1'b1;

        // Scenario 2: idle with enable low
        for (int i = 0; i < 5; i++) tick("hold0");
        cmp4("hold0_const", count_a, 4'd0);

        // Scenario 3: 20 enabled edges, wrap through 15 -> 0 -> 4
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick("run20");
            if (m_a == 15) cmp1("tc_at_15", tc_a, 1'b1);
        end
        cmp4("after20_const", count_a, 4'd4);

        // Scenario 4: pause at 7 for 5 cycles, then resume
        for (int i = 0; i < 3; i++) tick("to7");
        cmp4("at7_const", count_a, 4'd7);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick("pause7");
        cmp4("pause7_const", count_a, 4'd7);
        enable = 1'b1;
        tick("resume8");
        cmp4("resume8_const", count_a, 4'd8);
        tick("resume9");

        // Scenario 5: async clear between edges at 11, next enabled edge yields 1
        for (int i = 0; i < 2; i++) tick("to11");
        cmp4("at11_const", count_a, 4'd11);
        pulse_clr_mid("clr11");
        cmp4("clr11_const", count_a, 4'd0);
        tick("after_clr");
        cmp4("after_clr_const", count_a, 4'd1);

        // Scenario 6 coverage on the MAX_COUNT=9 instance: walk to 9 and probe tc with enable both ways
        while (m_b != 9) tick("to9");
        enable = 1'b0;
        #1;
        check_all("at9_en0");
        enable = 1'b1;
        #1;
        check_all("at9_en1");
        tick("wrap9");
        cmp4("wrap9_const", count_b, 4'd0);

        // Randomized stretch: random enable, occasional mid-cycle clear
        for (int i = 0; i < 300; i++) begin
            enable = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) pulse_clr_mid("rand_clr");
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
